// File: rtl/booth_multiplier_seq.sv
// booth_multiplier_seq
// Sequential radix-2 Booth multiplier for N-bit operands, signed or unsigned.
// A multiply is requested with start_i while idle; one Booth step
// (add/subtract fused with the arithmetic shift) runs per clock, N+1 steps in
// total, after which done_o pulses for one cycle and product_o holds the new
// result until the next done_o.
//
// Ports:
//   clk_i       system clock, all state changes on the rising edge
//   rst_i       asynchronous active-high reset
//   start_i     multiply request, sampled only while idle
//   signed_i    1 = two's-complement operands, 0 = unsigned (sampled with start_i)
//   plicand_i   multiplicand (sampled with start_i)
//   plier_i     multiplier (sampled with start_i)
//   busy_o      high while the iteration loop runs
//   done_o      one-cycle pulse, product_o valid from this cycle on
//   product_o   registered 2N-bit product
//   state_o     debug state: 00 idle, 01 run
module booth_multiplier_seq #(
    parameter int N = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [N-1:0]     plicand_i,
    input  logic [N-1:0]     plier_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [2*N-1:0]   product_o,
    output logic [1:0]       state_o
);

    localparam int CNT_W = $clog2(N + 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01
    } state_t;

    // Widen an operand to N+1 bits so both modes share one signed datapath.
    function automatic logic [N:0] extend(input logic [N-1:0] v, input logic sgn);
        return {sgn & v[N-1], v};
    endfunction

    state_t          state_q, state_d;
    logic [N+1:0]    m_q, m_d;
    logic [N+1:0]    a_q, a_d;
    logic [N:0]      q_q, q_d;
    logic            q1_q, q1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [2*N-1:0]  product_q, product_d;

    logic [N:0]      plicand_ext;
    logic [N:0]      plier_ext;
    logic [N+1:0]    alu_res;

    assign plicand_ext = extend(plicand_i, signed_i);
    assign plier_ext   = extend(plier_i, signed_i);

    // State and datapath registers, cleared asynchronously by rst_i.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    // Next-state logic: leave idle on start, return after the last iteration.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand load, Booth step and output register updates.
    always_comb begin
        m_d       = m_q;
        a_d       = a_q;
        q_d       = q_q;
        q1_d      = q1_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;
        alu_res   = a_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    m_d    = {plicand_ext[N], plicand_ext};
                    a_d    = '0;
                    q_d    = plier_ext;
                    q1_d   = 1'b0;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            RUN: begin
                case ({q_q[0], q1_q})
                    2'b01:   alu_res = a_q + m_q;
                    2'b10:   alu_res = a_q - m_q;
                    default: alu_res = a_q;
                endcase
                // Arithmetic right shift of {A', Q, Q_1}, replicating A' sign.
                a_d   = {alu_res[N+1], alu_res[N+1:1]};
                q_d   = {alu_res[0], q_q[N:1]};
                q1_d  = q_q[0];
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_CNT) begin
                    // The exact product fits in the low 2N bits of {A, Q}.
                    product_d = {a_d[N-2:0], q_d};
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = product_q;
    assign state_o   = state_q;

endmodule

// File: doc/booth_multiplier_seq.md
# booth_multiplier_seq

Parametrised sequential radix-2 Booth multiplier with a START/DONE handshake, selectable signed or unsigned operand mode, and a registered product that holds until the next result. It generalises the 4x4 signed shift-add multiplier to any width N. All state is updated on a single clock: add/subtract and arithmetic shift are fused into one cycle per iteration, with no strobe-edge sequencing. It sits in the lab datapath as the arithmetic unit behind a simple controller that issues one multiply at a time.

## Interface
- N, default 4: operand width in bits; legal range 2..32.
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- START  input  1  request a multiply; sampled only in IDLE.
- SIGNED  input  1  1 = two's-complement operands, 0 = unsigned; sampled with START.
- PLICAND  input  N  multiplicand; sampled with START.
- PLIER  input  N  multiplier; sampled with START.
- BUSY  output  1  high while in RUN.
- DONE  output  1  one-cycle pulse; PRODUCT is valid from this cycle on.
- PRODUCT  output  2N  registered result; held until the next DONE.
- STATE  output  2  debug: 00 IDLE, 01 RUN.

## Operation
- Working registers:
  - M (N+2 bits).
  - A (N+2 bits).
  - Q (N+1 bits).
  - Q_1 (1 bit).
  - CNT (ceil(log2(N+2)) bits).
- Operand extension to N+1 bits:
  - Sign-extend when SIGNED=1; zero-extend when SIGNED=0.
  - M is the extended PLICAND, sign-extended once more to N+2 bits.
- IDLE, START=1 at a rising edge:
  - Q <= extended PLIER; M <= extended PLICAND.
  - A <= 0; Q_1 <= 0; CNT <= 0.
  - BUSY <= 1; go to RUN.
- IDLE, START=0: hold. DONE=0.
- RUN, one iteration per cycle:
  - {Q[0],Q_1}=01: A' = A + M.
  - {Q[0],Q_1}=10: A' = A - M.
  - 00 or 11: A' = A.
  - Then arithmetic right shift of {A',Q,Q_1} by one, copying A'[N+1]; CNT increments.
  - Add/subtract is modulo 2^(N+2). No overflow is possible, because the extended operands are N+1 bits wide.
- RUN, last iteration (CNT = N):
  - PRODUCT <= low 2N bits of the post-shift {A,Q}.
  - DONE <= 1 for one cycle; BUSY <= 0; go to IDLE.
- Iteration count is always N+1 in both modes. In signed mode the extra iteration is a no-op, so latency is mode-independent.
- Result width: the exact signed (N+1)x(N+1) product always fits in 2N bits for both modes.
- START while BUSY: ignored. No queueing, no error.
- Input changes during RUN: no effect, because operands are latched.
- RESET asserted in any state, including mid-RUN:
  - Immediately clears all registers.
  - PRODUCT=0, DONE=0, BUSY=0, STATE=IDLE.
  - An in-flight operation is discarded with no DONE.
- RESET deasserted: first START is accepted at the next rising edge.

## Timing
- Reset values: PRODUCT=0, DONE=0, BUSY=0, STATE=00.
- START sampled at edge k:
  - BUSY high after edge k.
  - Iterations run at edges k+1 .. k+N+1.
  - DONE and the new PRODUCT are visible after edge k+N+1; BUSY is low in that same cycle.
- Latency: N+1 cycles from the START edge to DONE.
- DONE is high for exactly one cycle; it deasserts at edge k+N+2.
- START held high during the DONE cycle is accepted at edge k+N+2. Back-to-back throughput is one result per N+2 cycles.
- PRODUCT is stable between DONE pulses and never shows intermediate values.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- N=4, SIGNED=1:
  - -8 x -8 -> PRODUCT=0x40.
  - -8 x 7 -> 0xC8.
  - 0 x -5 -> 0x00.
  - Each DONE arrives exactly 5 cycles after its START edge and lasts 1 cycle.
- N=4, SIGNED=0:
  - 15 x 15 -> 0xE1.
  - The same bit patterns with SIGNED=1 -> 0x01.
  - 9 x 3 -> 0x1B.
- N=8:
  - SIGNED=0: 255 x 255 -> 0xFE01.
  - SIGNED=1: -128 x -128 -> 0x4000; -128 x 127 -> 0xC080.
  - Latency is 9 cycles.
- START pulsed at cycles 2 and 4 of RUN with different operands -> ignored. Exactly one DONE, carrying the first product. BUSY is continuously high until DONE.
- Back-to-back: START held high continuously -> DONE pulses every N+2 cycles, with correct alternating products.
- RESET pulsed asynchronously mid-RUN, between clock edges:
  - Outputs clear immediately; no DONE follows.
  - The next START completes normally with the correct product.
  - Exhaustive N=4 sweep in both modes, checked against a reference model.
